// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues one outstanding memory request at a time,
// and hands instructions to decode. Optional perf counters are enabled by FETCH_CTRL_PERF_EN.
//
// state | meaning
// IDLE  | fetch disabled, no request outstanding
// REQ   | mem_req asserted, waiting for mem_gnt
// WAIT  | request granted, waiting for mem_rvalid (kill marks a stale response)
// HOLD  | instruction presented to decode, waiting for instr_ready
module fetch_ctrl #(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
`ifdef FETCH_CTRL_PERF_EN
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_killed,
`endif
  output logic [DATA_WIDTH-1:0] instr_pc4
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  kill_q, kill_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                  fetched_evt;
  logic                  killed_evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    fetched_evt = 1'b0;
    killed_evt  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (redirect_valid) pc_d = redirect_pc;
        if (trigger) state_d = REQ;
      end
      REQ: begin
        if (redirect_valid) pc_d = redirect_pc;
        if (mem_gnt) begin
          state_d = WAIT;
          // granted fetch targets the old PC, so its response must be dropped
          if (redirect_valid) kill_d = 1'b1;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          if (kill_q || redirect_valid) begin
            killed_evt = 1'b1;
            kill_d     = 1'b0;
            if (redirect_valid) pc_d = redirect_pc;
            state_d    = trigger ? REQ : IDLE;
          end else begin
            instr_d    = mem_rdata;
            instr_pc_d = pc_q;
            state_d    = HOLD;
          end
        end else if (redirect_valid) begin
          pc_d   = redirect_pc;
          kill_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = trigger ? REQ : IDLE;
        end else if (instr_ready) begin
          fetched_evt = 1'b1;
          pc_d        = pc_q + PC_STEP;
          state_d     = trigger ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_killed_q, perf_killed_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + {31'd0, fetched_evt};
    perf_killed_d  = perf_killed_q + {31'd0, killed_evt};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_killed_q  <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_killed_q  <= perf_killed_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_killed  = perf_killed_q;
`else
  logic unused_evt;
  assign unused_evt = fetched_evt ^ killed_evt;
`endif

  assign mem_req     = (state_q == REQ);
  assign mem_addr    = pc_q;
  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_pc4   = instr_pc_q + PC_STEP;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: handshake latency, stalls, redirects/kills, wrap, async reset.
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        trigger, redirect_valid, mem_gnt, mem_rvalid, instr_ready;
  logic [31:0] redirect_pc, mem_rdata;
  logic        mem_req, instr_valid;
  logic [31:0] mem_addr, instr, instr_pc, instr_pc4;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetched, perf_killed;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .trigger(trigger),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
`ifdef FETCH_CTRL_PERF_EN
    .perf_fetched(perf_fetched), .perf_killed(perf_killed),
`endif
    .instr_pc4(instr_pc4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; trigger = 0; redirect_valid = 0; redirect_pc = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; instr_ready = 0;
    repeat (2) step();
    rst = 1'b0;
    #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got=%0b exp=0", mem_req); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid got=%0b exp=0", instr_valid); end
    n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h exp=0", instr); end
    n_checks++; if (instr_pc4 !== 32'h4) begin n_fail++; $display("FAIL reset_instr_pc4 got=%h exp=4", instr_pc4); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
  endtask

  task automatic test_basic_fetch();
    trigger = 1; mem_gnt = 1;
    step();  // IDLE -> REQ
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL basic_req got=%0b/%h exp=1/0", mem_req, mem_addr); end
    step();  // REQ -> WAIT
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h00500093;
    n_checks++; if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_wait got=%0b/%0b exp=0/0", mem_req, instr_valid); end
    step();  // WAIT -> HOLD
    mem_rvalid = 0; instr_ready = 1;
    n_checks++; if (instr_valid !== 1'b1 || instr !== 32'h00500093) begin n_fail++; $display("FAIL basic_instr got=%0b/%h exp=1/00500093", instr_valid, instr); end
    n_checks++; if (instr_pc !== 32'h0 || instr_pc4 !== 32'h4) begin n_fail++; $display("FAIL basic_pc got=%h/%h exp=0/4", instr_pc, instr_pc4); end
    step();  // HOLD -> REQ
    instr_ready = 0;
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin n_fail++; $display("FAIL basic_next got=%0b/%h exp=1/4", mem_req, mem_addr); end
  endtask

  task automatic test_stall();
    mem_gnt = 1;
    step();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hA5A5_0001;
    step();
    mem_rvalid = 0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (instr_valid !== 1'b1 || mem_req !== 1'b0 || instr !== 32'hA5A5_0001 || instr_pc !== 32'h4) begin
        n_fail++; $display("FAIL stall_hold[%0d] got=%0b/%0b/%h/%h exp=1/0/a5a50001/4", i, instr_valid, mem_req, instr, instr_pc);
      end
      step();
    end
    instr_ready = 1;
    step();
    instr_ready = 0;
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin n_fail++; $display("FAIL stall_next got=%0b/%h exp=1/8", mem_req, mem_addr); end
  endtask

  task automatic test_redirect_wait();
    mem_gnt = 1;
    step();  // -> WAIT
    mem_gnt = 0; redirect_valid = 1; redirect_pc = 32'h100;
    step();  // stays WAIT, kill set
    redirect_valid = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    n_checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL redir_wait_stay got=%0b/%0b exp=0/0", instr_valid, mem_req); end
    step();  // response dropped -> REQ
    mem_rvalid = 0;
    n_checks++; if (instr_valid !== 1'b0 || instr === 32'hDEADBEEF) begin n_fail++; $display("FAIL redir_wait_drop got=%0b/%h exp=0/not-deadbeef", instr_valid, instr); end
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_wait_addr got=%0b/%h exp=1/100", mem_req, mem_addr); end
  endtask

  task automatic test_redirect_gnt();
    mem_gnt = 1; redirect_valid = 1; redirect_pc = 32'h40;
    step();  // -> WAIT with kill
    mem_gnt = 0; redirect_valid = 0; mem_rvalid = 1; mem_rdata = 32'h1111_1111;
    step();  // dropped -> REQ
    mem_rvalid = 0;
    n_checks++; if (instr_valid !== 1'b0 || instr === 32'h1111_1111) begin n_fail++; $display("FAIL redir_gnt_drop got=%0b/%h exp=0/not-11111111", instr_valid, instr); end
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin n_fail++; $display("FAIL redir_gnt_addr got=%0b/%h exp=1/40", mem_req, mem_addr); end
  endtask

  task automatic test_gnt_stall();
    trigger = 0; mem_gnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin n_fail++; $display("FAIL gnt_stall[%0d] got=%0b/%h exp=1/40", i, mem_req, mem_addr); end
    end
    mem_gnt = 1;
    step();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h2222_2222;
    step();
    mem_rvalid = 0; instr_ready = 1;
    n_checks++; if (instr_valid !== 1'b1 || instr !== 32'h2222_2222 || instr_pc !== 32'h40) begin n_fail++; $display("FAIL gnt_stall_instr got=%0b/%h/%h exp=1/22222222/40", instr_valid, instr, instr_pc); end
    step();  // trigger low -> IDLE
    instr_ready = 0;
    n_checks++; if (mem_req !== 1'b0 || instr_valid !== 1'b0 || mem_addr !== 32'h44) begin n_fail++; $display("FAIL gnt_stall_idle got=%0b/%0b/%h exp=0/0/44", mem_req, instr_valid, mem_addr); end
    step();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL idle_stays got=%0b exp=0", mem_req); end
  endtask

  task automatic test_wrap_and_hold_redirect();
    trigger = 1; redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    step();  // IDLE -> REQ with redirected pc
    redirect_valid = 0; mem_gnt = 1;
    n_checks++; if (mem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr got=%h exp=fffffffc", mem_addr); end
    step();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h3333_3333;
    step();
    mem_rvalid = 0;
    n_checks++; if (instr_pc !== 32'hFFFF_FFFC || instr_pc4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4 got=%h/%h exp=fffffffc/0", instr_pc, instr_pc4); end
    instr_ready = 1; redirect_valid = 1; redirect_pc = 32'h80;
    step();  // redirect wins over pc+4
    instr_ready = 0; redirect_valid = 0;
    n_checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h80) begin n_fail++; $display("FAIL hold_redirect got=%0b/%0b/%h exp=0/1/80", instr_valid, mem_req, mem_addr); end
  endtask

  task automatic test_reset_mid_wait();
`ifdef FETCH_CTRL_PERF_EN
    n_checks++; if (perf_fetched !== 32'd3 || perf_killed !== 32'd2) begin n_fail++; $display("FAIL perf_counts got=%0d/%0d exp=3/2", perf_fetched, perf_killed); end
`endif
    mem_gnt = 1;
    step();  // -> WAIT
    mem_gnt = 0; trigger = 0;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (mem_req !== 1'b0 || instr_valid !== 1'b0 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL async_reset got=%0b/%0b/%h exp=0/0/0", mem_req, instr_valid, mem_addr); end
    step();
    rst = 1'b0;
    mem_rvalid = 1; mem_rdata = 32'h4444_4444;
    step();
    mem_rvalid = 0;
    step();
    n_checks++; if (instr_valid !== 1'b0 || instr !== 32'h0 || mem_addr !== 32'h0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL stray_rvalid got=%0b/%h/%h/%0b exp=0/0/0/0", instr_valid, instr, mem_addr, mem_req); end
`ifdef FETCH_CTRL_PERF_EN
    n_checks++; if (perf_fetched !== 32'd0 || perf_killed !== 32'd0) begin n_fail++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", perf_fetched, perf_killed); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_gnt();
    test_gnt_stall();
    test_wrap_and_hold_redirect();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencing controller for the fetch stage, driving an instruction memory with a request/grant/response handshake instead of a combinational ROM. It owns the PC, issues one outstanding fetch at a time, and presents each instruction to decode with a valid/ready handshake. It also applies branch/jump redirects and kills in-flight fetches made stale by a redirect. It sits between the branch-resolution logic (redirect) and decode.

Parameters:
DATA_WIDTH, 32, width of PC, address and instruction
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
trigger  input  1  fetch enable; gates starting a new request
redirect_valid  input  1  taken branch/jump this cycle
redirect_pc  input  DATA_WIDTH  redirect target
mem_req  output  1  memory request
mem_addr  output  DATA_WIDTH  request address (equals current PC)
mem_gnt  input  1  memory accepted the request this cycle
mem_rvalid  input  1  read data valid
mem_rdata  input  DATA_WIDTH  instruction word
instr_valid  output  1  instruction available to decode
instr_ready  input  1  decode accepts the instruction
instr  output  DATA_WIDTH  held instruction word
instr_pc  output  DATA_WIDTH  PC of the held instruction
instr_pc4  output  DATA_WIDTH  instr_pc + 4, combinational, modulo 2^DATA_WIDTH

Behaviour:
- Reset (async, any state):
  - state=IDLE, pc=RESET_PC, kill=0.
  - mem_req=0, instr_valid=0, instr=0, instr_pc=RESET_PC (so instr_pc4=RESET_PC+4).
- mem_addr = pc at all times.
- mem_req = 1 only in state REQ.
- instr_valid = 1 only in state HOLD.
- IDLE:
  - trigger=1 -> REQ.
  - redirect_valid -> pc<=redirect_pc; stay IDLE unless trigger=1.
- REQ:
  - mem_req held high until mem_gnt, regardless of trigger.
  - redirect without gnt -> pc<=redirect_pc, stay REQ. The new address is presented next cycle; this is legal because nothing was granted.
  - gnt without redirect -> WAIT.
  - gnt with redirect in the same cycle -> WAIT, kill<=1, pc<=redirect_pc.
- WAIT:
  - mem_rvalid ignored in every state except WAIT.
  - rvalid, kill=0, no redirect -> instr<=mem_rdata, instr_pc<=pc; -> HOLD.
  - rvalid, kill=1 -> response dropped, kill<=0; -> REQ if trigger else IDLE.
  - rvalid with redirect (either kill value) -> response dropped, kill<=0, pc<=redirect_pc; -> REQ if trigger else IDLE.
  - redirect without rvalid -> pc<=redirect_pc, kill<=1, stay WAIT.
- HOLD:
  - instr, instr_pc stable while instr_ready=0.
  - instr_ready, no redirect -> pc<=pc+4; -> REQ if trigger else IDLE.
  - redirect (with or without ready) -> pc<=redirect_pc, instr_valid drops next cycle; -> REQ if trigger else IDLE. Redirect wins over pc+4.
- Latency and throughput:
  - With 1-cycle gnt, rvalid one cycle after gnt, and ready=1: the sequence is REQ, WAIT, HOLD, giving 1 instruction per 3 cycles.
  - instr_valid rises on the edge after rvalid.
- pc+4 wraps modulo 2^DATA_WIDTH; no alignment checking.
- A new request is never issued while one is outstanding.
- Reset mid-WAIT: a late rvalid arriving after reset is ignored, because the FSM is not in WAIT.

Optional Feature:
- Macro: FETCH_CTRL_PERF_EN.
- Defined:
  - Adds output ports perf_fetched [31:0] and perf_killed [31:0]; both reset to 0 and wrap at 2^32.
  - perf_fetched increments on each HOLD handshake (instr_valid & instr_ready & !redirect_valid).
  - perf_killed increments on each dropped response (WAIT & rvalid & (kill | redirect_valid)).
- Undefined:
  - Ports and counters absent.
  - All other behaviour identical.

Test Plan:
1. Reset, trigger=1, gnt=1 on first REQ cycle, rvalid one cycle later with rdata=32'h00500093, ready=1 -> mem_addr=0x0; instr_valid=1 with instr=0x00500093, instr_pc=0x0, instr_pc4=0x4; next mem_addr=0x4.
2. Stall: hold instr_ready=0 for 5 cycles in HOLD -> instr/instr_pc unchanged, mem_req=0; after ready=1, next request at instr_pc+4.
3. Redirect to 0x100 during WAIT, then rvalid with 0xDEADBEEF -> 0xDEADBEEF never appears on instr with instr_valid=1; next mem_addr=0x100.
4. Redirect to 0x40 in the same cycle as mem_gnt in REQ -> the following response is dropped; next request mem_addr=0x40.
5. Hold gnt=0 for 4 cycles with trigger dropped to 0 -> mem_req stays 1 with mem_addr stable until gnt. After the response and accept -> IDLE, mem_req=0.
6. Assert rst asynchronously mid-WAIT, then a stray rvalid after release -> instr_valid=0, pc=RESET_PC, stray data ignored. With FETCH_CTRL_PERF_EN defined, perf counters read 0.
